// File: rtl/group_serializer_if.sv
// Handshake bundle between a word producer, the serializer and a 1-bit-per-cycle consumer.
interface group_serializer_if #(
    parameter int unsigned groupSize = 16
);
    logic                 load;
    logic [groupSize-1:0] groupedElements;
    logic                 ready;
    logic                 advance;
    logic                 element;
    logic                 elementValid;
    logic                 lastElement;

    modport master (
        output load, groupedElements, advance,
        input  ready, element, elementValid, lastElement
    );

    modport slave (
        input  load, groupedElements, advance,
        output ready, element, elementValid, lastElement
    );
endinterface

// File: rtl/group_serializer.sv
// Parallel-to-serial converter, MSB first, with a one-deep holding register so that
// back-to-back words stream without a gap.
module group_serializer #(
    parameter int unsigned groupSize           = 16,
    parameter int unsigned sizeOfCounterInBits = 4
) (
    input logic               clock,
    input logic               resetN,
    group_serializer_if.slave bus
);
    localparam logic [sizeOfCounterInBits-1:0] LastIdx = sizeOfCounterInBits'(groupSize - 1);

    logic [groupSize-1:0]           shiftReg, shiftRegNext;
    logic [groupSize-1:0]           holdReg, holdRegNext;
    logic [sizeOfCounterInBits-1:0] bitIdx, bitIdxNext;
    logic                           active, activeNext;
    logic                           holdFull, holdFullNext;

    logic consume, accept, isLast, bypass;

    assign bus.ready        = resetN && !holdFull;
    assign bus.elementValid = active;
    assign bus.lastElement  = active && (bitIdx == LastIdx);
    assign bus.element      = shiftReg[groupSize-1];

    assign consume = active && bus.advance;
    assign accept  = bus.load && bus.ready;
    assign isLast  = (bitIdx == LastIdx);

    always_comb begin
        shiftRegNext = shiftReg;
        holdRegNext  = holdReg;
        bitIdxNext   = bitIdx;
        activeNext   = active;
        holdFullNext = holdFull;
        bypass       = 1'b0;

        if (consume) begin
            if (!isLast) begin
                shiftRegNext = {shiftReg[groupSize-2:0], 1'b0};
                bitIdxNext   = bitIdx + 1'b1;
            end else if (holdFull) begin
                shiftRegNext = holdReg;
                holdFullNext = 1'b0;
                bitIdxNext   = '0;
            end else if (accept) begin
                shiftRegNext = bus.groupedElements;
                bitIdxNext   = '0;
                bypass       = 1'b1;
            end else begin
                // Shifting out the final bit leaves shiftReg all-zero, so element idles at 0.
                shiftRegNext = {shiftReg[groupSize-2:0], 1'b0};
                bitIdxNext   = '0;
                activeNext   = 1'b0;
            end
        end

        if (accept && !bypass) begin
            if (!active) begin
                shiftRegNext = bus.groupedElements;
                bitIdxNext   = '0;
                activeNext   = 1'b1;
            end else begin
                holdRegNext  = bus.groupedElements;
                holdFullNext = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            shiftReg <= '0;
            holdReg  <= '0;
            bitIdx   <= '0;
            active   <= 1'b0;
            holdFull <= 1'b0;
        end else begin
            shiftReg <= shiftRegNext;
            holdReg  <= holdRegNext;
            bitIdx   <= bitIdxNext;
            active   <= activeNext;
            holdFull <= holdFullNext;
        end
    end
endmodule

// File: tb/tb_group_serializer.sv
// Randomised and directed bench for group_serializer against a word-queue reference model.
module tb_group_serializer;
    logic clock = 1'b0;
    logic resetN = 1'b0;

    group_serializer_if #(.groupSize(16)) bus ();

    group_serializer #(
        .groupSize(16),
        .sizeOfCounterInBits(4)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: queue of pending words (front = shifting, second = held) plus bit position.
    logic [15:0] mq[$];
    int          pos = 0;
    bit          mCons, mAcc;

    // Bits actually consumed by the downstream side, for whole-stream literal checks.
    bit          rec[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (!resetN) begin
            mq.delete();
            pos = 0;
        end else begin
            mCons = (mq.size() > 0) && bus.advance;
            mAcc  = bus.load && (mq.size() < 2);
            if (mCons) begin
                if (pos == 15) begin
                    void'(mq.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (mAcc) mq.push_back(bus.groupedElements);
        end
    end

    always @(negedge clock) begin
        logic       expValid, expElem, expLast, expReady;
        logic [15:0] front;
        expValid = mq.size() > 0;
        front    = expValid ? mq[0] : 16'h0;
        expElem  = expValid ? front[15-pos] : 1'b0;
        expLast  = expValid && (pos == 15);
        expReady = resetN && (mq.size() < 2);
        check("ready", 32'(bus.ready), 32'(expReady));
        check("elementValid", 32'(bus.elementValid), 32'(expValid));
        check("element", 32'(bus.element), 32'(expElem));
        check("lastElement", 32'(bus.lastElement), 32'(expLast));
        if (resetN && bus.elementValid && bus.advance) rec.push_back(bus.element);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        bus.load            = 1'b1;
        bus.groupedElements = w;
        tick();
        bus.load            = 1'b0;
    endtask

    function automatic logic [31:0] packRec();
        logic [31:0] v = '0;
        foreach (rec[i]) v = {v[30:0], rec[i]};
        return v;
    endfunction

    initial begin
        bit found;
        bus.load            = 1'b0;
        bus.advance         = 1'b0;
        bus.groupedElements = '0;

        repeat (3) tick();
        check("ready_in_reset", 32'(bus.ready), 32'h0);
        resetN = 1'b1;
        tick();
        check("idle_ready", 32'(bus.ready), 32'h1);
        check("idle_element", 32'(bus.element), 32'h0);
        bus.advance = 1'b1;
        repeat (5) tick();
        check("idle_valid_after_advance", 32'(bus.elementValid), 32'h0);

        // Single word
        rec.delete();
        send(16'hA5C3);
        repeat (18) tick();
        check("single_len", 32'(rec.size()), 32'd16);
        check("single_word", packRec(), 32'h0000A5C3);
        check("single_valid_after", 32'(bus.elementValid), 32'h0);

        // Back-to-back with hold
        rec.delete();
        send(16'hFFFF);
        send(16'h0001);
        check("b2b_ready_low", 32'(bus.ready), 32'h0);
        repeat (34) tick();
        check("b2b_len", 32'(rec.size()), 32'd32);
        check("b2b_stream", packRec(), 32'hFFFF0001);

        // Bypass on the last-bit cycle
        send(16'h1357);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.lastElement) found = 1'b1;
            else tick();
        end
        check("bypass_found_last", 32'(found), 32'h1);
        send(16'h8000);
        check("bypass_element", 32'(bus.element), 32'h1);
        check("bypass_valid", 32'(bus.elementValid), 32'h1);
        check("bypass_not_held", 32'(bus.ready), 32'h1);
        repeat (18) tick();

        // Stall, with a held word and an ignored extra load
        rec.delete();
        send(16'h00F0);
        repeat (4) tick();
        bus.advance = 1'b0;
        send(16'h0F0F);
        bus.load            = 1'b1;
        bus.groupedElements = 16'hFFFF;
        tick();
        tick();
        check("stall_element_held", 32'(bus.element), 32'h0);
        check("stall_ready_low", 32'(bus.ready), 32'h0);
        bus.load    = 1'b0;
        bus.advance = 1'b1;
        repeat (36) tick();
        check("stall_stream", packRec(), 32'h00F00F0F);

        // Reset mid-stream with a held word
        send(16'hAAAA);
        send(16'h5555);
        repeat (6) tick();
        resetN = 1'b0;
        tick();
        check("rst_valid", 32'(bus.elementValid), 32'h0);
        resetN = 1'b1;
        tick();
        rec.delete();
        send(16'h1234);
        repeat (18) tick();
        check("rst_fresh_len", 32'(rec.size()), 32'd16);
        check("rst_fresh_word", packRec(), 32'h00001234);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            resetN              = ($urandom_range(0, 199) != 0);
            bus.load            = ($urandom_range(0, 2) == 0);
            bus.advance         = ($urandom_range(0, 3) != 0);
            bus.groupedElements = 16'($urandom);
            tick();
        end
        resetN   = 1'b1;
        bus.load = 1'b0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
